// File: rtl/sprite_plot_scheduler_pkg.sv
// Shared definitions for the sprite plot scheduler: FSM encoding and screen geometry.
package sprite_plot_scheduler_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] DEFAULT_BG_COLOUR = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_ERASE = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sprite_plot_scheduler_rr_arbiter.sv
// Round-robin pick of the first active request at or after the pointer, registered on load.
module sprite_plot_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               load,
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx
);

  logic               pick_found;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;

  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_oh    = '0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!pick_found && req[cand]) begin
        pick_found    = 1'b1;
        pick_oh[cand] = 1'b1;
        pick_idx      = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      grant_oh  <= '0;
      grant_idx <= '0;
    end else if (load && pick_found) begin
      grant_oh  <= pick_oh;
      grant_idx <= pick_idx;
    end
  end

endmodule

// File: rtl/sprite_plot_scheduler.sv
// Arbitrates movers onto the single VGA write port: erase old sprite box, draw new one, ack.
module sprite_plot_scheduler
  import sprite_plot_scheduler_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter int         SPR_W     = 10,
  parameter int         SPR_H     = 11,
  parameter logic [2:0] BG_COLOUR = DEFAULT_BG_COLOUR
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] old_x,
  input  logic [NUM_REQ*7-1:0] old_y,
  input  logic [NUM_REQ*8-1:0] new_x,
  input  logic [NUM_REQ*7-1:0] new_y,
  input  logic [NUM_REQ*3-1:0] colour,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 plot,
  output logic [7:0]           vgaX,
  output logic [6:0]           vgaY,
  output logic [2:0]           vgaColour
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int CY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  state_t state_reg, state_next;

  logic [IDX_W-1:0]   ptr_reg;
  logic [CX_W-1:0]    cx_reg;
  logic [CY_W-1:0]    cy_reg;
  logic [7:0]         ox_reg, nx_reg;
  logic [6:0]         oy_reg, ny_reg;
  logic [2:0]         col_reg;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   grant_idx;

  logic [7:0] old_x_arr [NUM_REQ];
  logic [6:0] old_y_arr [NUM_REQ];
  logic [7:0] new_x_arr [NUM_REQ];
  logic [6:0] new_y_arr [NUM_REQ];
  logic [2:0] colour_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign old_x_arr[gi]  = old_x[8*gi +: 8];
      assign old_y_arr[gi]  = old_y[7*gi +: 7];
      assign new_x_arr[gi]  = new_x[8*gi +: 8];
      assign new_y_arr[gi]  = new_y[7*gi +: 7];
      assign colour_arr[gi] = colour[3*gi +: 3];
    end
  endgenerate

  sprite_plot_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .load      (state_reg == ST_IDLE),
    .req       (req),
    .ptr       (ptr_reg),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  logic last_px;
  logic same_pos;
  assign last_px  = (cx_reg == CX_W'(SPR_W - 1)) && (cy_reg == CY_W'(SPR_H - 1));
  assign same_pos = (old_x_arr[grant_idx] == new_x_arr[grant_idx]) &&
                    (old_y_arr[grant_idx] == new_y_arr[grant_idx]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (|req) state_next = ST_LATCH;
      ST_LATCH: state_next = same_pos ? ST_DRAW : ST_ERASE;
      ST_ERASE: if (last_px) state_next = ST_DRAW;
      ST_DRAW:  if (last_px) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      cx_reg    <= '0;
      cy_reg    <= '0;
      ox_reg    <= '0;
      oy_reg    <= '0;
      nx_reg    <= '0;
      ny_reg    <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_LATCH) begin
        ox_reg  <= old_x_arr[grant_idx];
        oy_reg  <= old_y_arr[grant_idx];
        nx_reg  <= new_x_arr[grant_idx];
        ny_reg  <= new_y_arr[grant_idx];
        col_reg <= colour_arr[grant_idx];
      end
      // Row-major scan; the last pixel wraps both counters so the next phase starts at 0.
      if (state_reg == ST_ERASE || state_reg == ST_DRAW) begin
        if (cx_reg == CX_W'(SPR_W - 1)) begin
          cx_reg <= '0;
          cy_reg <= last_px ? '0 : cy_reg + CY_W'(1);
        end else begin
          cx_reg <= cx_reg + CX_W'(1);
        end
      end else begin
        cx_reg <= '0;
        cy_reg <= '0;
      end
      if (state_reg == ST_DONE)
        ptr_reg <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  logic       scanning;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  always_comb begin
    scanning  = (state_reg == ST_ERASE) || (state_reg == ST_DRAW);
    base_x    = (state_reg == ST_ERASE) ? ox_reg : nx_reg;
    base_y    = (state_reg == ST_ERASE) ? oy_reg : ny_reg;
    sum_x     = {1'b0, base_x} + 9'(cx_reg);
    sum_y     = {1'b0, base_y} + 8'(cy_reg);
    plot      = 1'b0;
    vgaX      = '0;
    vgaY      = '0;
    vgaColour = '0;
    if (scanning) begin
      // Off-screen pixels still take their cycle, only the write enable is suppressed.
      plot      = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
      vgaX      = sum_x[7:0];
      vgaY      = sum_y[6:0];
      vgaColour = (state_reg == ST_ERASE) ? BG_COLOUR : col_reg;
    end
  end

  assign ack  = (state_reg == ST_DONE) ? grant_oh : '0;
  assign busy = (state_reg != ST_IDLE);

endmodule
